// File: rtl/fpga_conf_regs.sv
// SPI configuration register bank with blanked major-mode switching.
// Optional readback on miso is enabled by defining FPGA_CONF_READBACK_EN.
module fpga_conf_regs #(
    parameter int NREGS       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLDOFF     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   ck_1356meg,
    input  logic                   rst,
    input  logic                   spck,
    input  logic                   ncs,
    input  logic                   mosi,
    output logic                   miso,
    output logic [NREGS*WIDTH-1:0] conf_flat,
    output logic [NREGS-1:0]       wr_strobe,
    output logic [2:0]             major_mode,
    output logic                   mode_blank,
    output logic                   frame_err
);

    localparam logic [0:0]       RUN   = 1'b0;
    localparam logic [0:0]       BLANK = 1'b1;
    localparam logic [7:0]       HOLD  = 8'(HOLDOFF);
    localparam logic [WIDTH-1:0] RST0  = WIDTH'(7) << (WIDTH - 3);

    logic [SYNC_STAGES-1:0] spck_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   spck_q;
    logic                   ncs_q;

    // ncs chain resets low so a frame already in flight cannot fake a fall
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            spck_sync <= '0;
            ncs_sync  <= '0;
            mosi_sync <= '0;
            spck_q    <= 1'b0;
            ncs_q     <= 1'b0;
        end else begin
            spck_sync <= {spck_sync[SYNC_STAGES-2:0], spck};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            spck_q    <= spck_sync[SYNC_STAGES-1];
            ncs_q     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    logic spck_s, ncs_s, mosi_s;
    logic spck_rise, spck_fall, ncs_rise, ncs_fall;

    assign spck_s    = spck_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign spck_rise = spck_s & ~spck_q;
    assign spck_fall = ~spck_s & spck_q;
    assign ncs_rise  = ncs_s & ~ncs_q;
    assign ncs_fall  = ~ncs_s & ncs_q;

    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    logic        armed;

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            armed   <= 1'b0;
        end else if (ncs_fall) begin
            bit_cnt <= '0;
            armed   <= 1'b1;
        end else if (ncs_rise) begin
            armed <= 1'b0;
        end else if (armed && spck_rise && !ncs_s) begin
            shreg <= {shreg[14:0], mosi_s};
            if (bit_cnt != 5'd17)
                bit_cnt <= bit_cnt + 5'd1;
        end
    end

    logic [3:0]       cmd;
    logic [NREGS-1:0] wr_next;
    logic             err_next;
`ifdef FPGA_CONF_READBACK_EN
    logic             idx_load;
`endif

    assign cmd = shreg[15:12];

    always_comb begin
        wr_next  = '0;
        err_next = 1'b0;
`ifdef FPGA_CONF_READBACK_EN
        idx_load = 1'b0;
`endif
        if (ncs_rise && armed) begin
            if (bit_cnt != 5'd16) begin
                err_next = 1'b1;
            end else if (cmd == 4'h0) begin
                err_next = 1'b0;
            end else if (cmd == 4'hF) begin
`ifdef FPGA_CONF_READBACK_EN
                if (int'(shreg[3:0]) < NREGS)
                    idx_load = 1'b1;
                else
                    err_next = 1'b1;
`else
                err_next = 1'b1;
`endif
            end else if (int'(cmd) > NREGS) begin
                err_next = 1'b1;
            end else begin
                for (int i = 0; i < NREGS; i++)
                    if (cmd == 4'(i + 1))
                        wr_next[i] = 1'b1;
            end
        end
    end

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == 0) ? RST0 : '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (wr_next[i])
                    regs[i] <= shreg[WIDTH-1:0];
            wr_strobe <= wr_next;
            frame_err <= err_next;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign conf_flat[g*WIDTH +: WIDTH] = regs[g];
    end

    logic [0:0] state;
    logic [7:0] blank_cnt;
    logic [2:0] applied;
    logic [2:0] req_mode;
    logic       mode_chg;

    assign req_mode = regs[0][WIDTH-1:WIDTH-3];
    assign mode_chg = wr_strobe[0] && (req_mode != applied);

    // A differing commit during blanking restarts the full interval
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            state     <= RUN;
            blank_cnt <= '0;
            applied   <= 3'b111;
        end else begin
            case (state)
                RUN: begin
                    if (mode_chg) begin
                        state     <= BLANK;
                        blank_cnt <= HOLD;
                    end
                end
                BLANK: begin
                    if (mode_chg) begin
                        blank_cnt <= HOLD;
                    end else if (blank_cnt == 8'd0) begin
                        applied <= req_mode;
                        state   <= RUN;
                    end else begin
                        blank_cnt <= blank_cnt - 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign mode_blank = (state == BLANK);
    assign major_mode = (state == BLANK) ? 3'b111 : applied;

    logic unused_bits;
    assign unused_bits = ^{shreg, spck_fall};

`ifdef FPGA_CONF_READBACK_EN
    logic [3:0]  rd_idx;
    logic [15:0] rb_word;
    logic [15:0] out_sr;

    always_comb begin
        rb_word = 16'hF000;
        for (int i = 0; i < NREGS; i++)
            if (rd_idx == 4'(i))
                rb_word = 16'hF000 | 16'(regs[i]);
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            rd_idx <= '0;
            out_sr <= '0;
            miso   <= 1'b0;
        end else begin
            if (idx_load)
                rd_idx <= shreg[3:0];
            if (ncs_s) begin
                miso <= 1'b0;
            end else if (ncs_fall) begin
                out_sr <= rb_word;
            end else if (armed && spck_fall) begin
                miso   <= out_sr[15];
                out_sr <= {out_sr[14:0], 1'b0};
            end
        end
    end
`else
    assign miso = 1'b0;
`endif

endmodule
